// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied once after the last step.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;

    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic [XLEN-1:0] opd_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Products are negated as a full 2*XLEN value; quotient and remainder independently.
    function automatic logic [XLEN-1:0] sign_fix(input logic [2:0] f3, input logic neg,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = {hi, lo};
        if (neg) prod = -prod;
        case (f3)
            3'b000:                res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:        res = neg ? -lo : lo;
            default:               res = neg ? -hi : hi;
        endcase
        return res;
    endfunction

    logic signed [XLEN-1:0] a_s, b_s;
    logic            a_signed, b_signed, a_neg, b_neg, is_div, neg_sel;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    assign a_s      = op_a_i;
    assign b_s      = op_b_i;
    assign is_div   = funct3_i[2];
    assign a_signed = (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
    assign b_signed = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign a_neg    = a_signed && (a_s < 0);
    assign b_neg    = b_signed && (b_s < 0);
    assign abs_a    = magnitude(op_a_i, a_neg);
    assign abs_b    = magnitude(op_b_i, b_neg);
    // REM takes the dividend's sign; everything else takes the XOR of operand signs.
    assign neg_sel  = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = is_div && (op_b_i == '0);
    assign div_ovf  = is_div && !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (op_b_i == '1);
    assign fast     = div_zero || div_ovf;
    assign fast_res = div_zero ? (funct3_i[1] ? op_a_i : '1)
                               : (funct3_i[1] ? '0 : op_a_i);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_fits;
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opd_q : '0)};
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_fits  = div_shift >= {1'b0, opd_q};
    assign div_diff  = div_shift[XLEN-1:0] - opd_q;

    always_comb begin
        hi_nxt = mul_sum[XLEN:1];
        lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
        if (funct3_q[2]) begin
            hi_nxt = div_fits ? div_diff : div_shift[XLEN-1:0];
            lo_nxt = {acc_lo[XLEN-2:0], div_fits};
        end
    end

    assign stall_o = ((state == IDLE) && valid_i && !flush_i) || (state == BUSY);

    // Control: state, counter and the registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            count    <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            count  <= '0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    count  <= '0;
                    if (valid_i) begin
                        if (fast) begin
                            result_o <= fast_res;
                            rd_o     <= rd_i;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        result_o <= sign_fix(funct3_q, neg_q, hi_nxt, lo_nxt);
                        rd_o     <= rd_q;
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Datapath: operands captured while idle, one iteration per busy cycle.
    always_ff @(posedge clk_i) begin
        if (state == IDLE) begin
            funct3_q <= funct3_i;
            rd_q     <= rd_i;
            neg_q    <= neg_sel;
            acc_hi   <= '0;
            opd_q    <= is_div ? abs_b : abs_a;
            acc_lo   <= is_div ? abs_a : abs_b;
        end else if (state == BUSY) begin
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed corner cases, flush/reset aborts and random ops
// compared against a plain-arithmetic RV32M model.
module tb_ex_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_result;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct3_i(funct3_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one op in the current (idle) cycle and follows it to its done cycle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        logic fast;
        int lat;
        exp  = ref_op(f3, a, b);
        fast = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        lat  = fast ? 1 : 33;
        valid_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd;
        #1;
        chk({tag, " accept stall/done"}, {30'b0, stall_o, done_o}, 32'b10);
        for (int k = 1; k < lat; k++) begin
            tick();
            op_a_i = $urandom;
            op_b_i = $urandom;
            if (k == 1 || k == lat - 1)
                chk({tag, " busy stall/done"}, {30'b0, stall_o, done_o}, 32'b10);
        end
        tick();
        chk({tag, " done stall/done"}, {30'b0, stall_o, done_o}, 32'b01);
        chk({tag, " result"}, result_o, exp);
        chk({tag, " rd"}, {27'b0, rd_o}, {27'b0, rd});
        last_result = exp;
        tick();
        chk({tag, " after done"}, {30'b0, stall_o, done_o}, 32'b10);
    endtask

    initial begin
        rst_i = 1'b0; valid_i = 1'b0; funct3_i = 3'd0; op_a_i = '0; op_b_i = '0;
        rd_i = '0; flush_i = 1'b0;
        repeat (3) tick();
        chk("reset stall/done", {30'b0, stall_o, done_o}, 32'b00);
        chk("reset result", result_o, 32'h0);
        chk("reset rd", {27'b0, rd_o}, 32'h0);
        rst_i = 1'b1;
        tick();

        run_op("mul 7*6", 3'd0, 32'd7, 32'd6, 5'd5);
        run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd8);
        run_op("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd9);
        run_op("divu x/0", 3'd5, 32'h1234_5678, 32'd0, 5'd10);
        run_op("rem 5/0", 3'd6, 32'd5, 32'd0, 5'd11);
        run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op("mulh -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14);
        run_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15);
        run_op("mulhsu -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd16);

        // Flush while the counter is at 10.
        valid_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd9; rd_i = 5'd20;
        repeat (11) tick();
        valid_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("flush busy stall", {31'b0, stall_o}, 32'b1);
        tick();
        flush_i = 1'b0;
        chk("flush stall/done", {30'b0, stall_o, done_o}, 32'b00);
        chk("flush result hold", result_o, last_result);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 29) chk("flush no late done", {31'b0, done_o}, 32'b0);
        end
        run_op("mul after flush", 3'd0, 32'hFFFF_FFFD, 32'd11, 5'd21);

        // Reset in the middle of a busy divide.
        valid_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd22;
        repeat (6) tick();
        rst_i = 1'b0; valid_i = 1'b0;
        tick();
        chk("midrst stall/done", {30'b0, stall_o, done_o}, 32'b00);
        chk("midrst result", result_o, 32'h0);
        chk("midrst rd", {27'b0, rd_o}, 32'h0);
        rst_i = 1'b1;
        tick();
        run_op("b2b op1", 3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd23);
        run_op("b2b op2", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd24);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, 5'($urandom_range(0, 31)));
        end

        valid_i = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
